resp_misr: RTL and testbench

// - Response compactor placed directly downstream of the gate-level DUT; it consumes the DUT output word once per applied pattern.
// - Folds each accepted response into a multiple-input signature register (MISR) using a valid/ready handshake.
// - After N_PATT responses it compares the signature with a golden value and reports pass/fail.
// - Lets a pattern campaign be judged from a single signature instead of per-pattern output compares.

---
 rtl/resp_misr.sv | 119 +++++++++++
 tb/tb_resp_misr.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_misr.sv
// Response compactor: folds accepted DUT responses into a MISR signature.
// After N_PATT accepts, the signature is compared against golden and the result is reported.
module resp_misr #(
  parameter int               WIDTH  = 2,
  parameter int               SIG_W  = 8,
  parameter logic [SIG_W-1:0] POLY   = 8'h1D,
  parameter logic [SIG_W-1:0] SEED   = 8'h00,
  parameter int               N_PATT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] resp_i,
  input  logic             resp_valid_i,
  output logic             resp_ready_o,
  input  logic [SIG_W-1:0] golden_i,
  output logic [SIG_W-1:0] sig_o,
  output logic [15:0]      count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] LAST_CNT = 16'(N_PATT - 1);

  // Shift left, fold the polynomial back in when the MSB falls out, then XOR the response in.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [WIDTH-1:0] r);
    logic [SIG_W-1:0] fb;
    fb = s[SIG_W-1] ? POLY : {SIG_W{1'b0}};
    return {s[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(r);
  endfunction

  state_e           state_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [15:0]      count_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             accept_s;
  logic             last_s;

  // Next signature and handshake decode
  always_comb begin
    sig_d    = misr_step(sig_q, resp_i);
    accept_s = resp_valid_i & ready_q;
    if (count_q == LAST_CNT) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      count_q <= 16'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q <= ST_RUN;
            sig_q   <= SEED;
            count_q <= 16'd0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            sig_q   <= sig_d;
            count_q <= count_q + 16'd1;
            // pass compares the value being written now, not the old signature
            if (last_s) begin
              state_q <= ST_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (sig_d == golden_i);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sig_q   <= SEED;
          count_q <= 16'd0;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign resp_ready_o = ready_q;
  assign sig_o        = sig_q;
  assign count_o      = count_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;

endmodule

// File: tb/tb_resp_misr.sv
// Self-checking bench for resp_misr: directed scenarios plus randomized runs
// checked against a signature model computed from the MISR update rule.
module tb_resp_misr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start_a, valid_a, ready_a, busy_a, done_a, pass_a;
  logic [1:0] resp_a;
  logic [7:0] golden_a, sig_a;
  logic [15:0] count_a;

  logic       start_b, valid_b, ready_b, busy_b, done_b, pass_b;
  logic [1:0] resp_b;
  logic [7:0] golden_b, sig_b;
  logic [15:0] count_b;

  int tests_run    = 0;
  int tests_failed = 0;

  resp_misr u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .resp_i(resp_a),
    .resp_valid_i(valid_a), .resp_ready_o(ready_a), .golden_i(golden_a),
    .sig_o(sig_a), .count_o(count_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a)
  );

  resp_misr #(.SEED(8'h80), .N_PATT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .resp_i(resp_b),
    .resp_valid_i(valid_b), .resp_ready_o(ready_b), .golden_i(golden_b),
    .sig_o(sig_b), .count_o(count_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b)
  );

  // Signature model: multiply by x modulo x^8 + POLY, then add the response word.
  function automatic logic [7:0] model_step(input logic [7:0] s, input logic [1:0] r);
    int v;
    v = int'(s) * 2;
    if (v >= 256) v = (v - 256) ^ 'h1D;
    return 8'(v) ^ {6'd0, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b0; valid_a = 1'b0; resp_a = 2'd0; golden_a = 8'd0;
    start_b = 1'b0; valid_b = 1'b0; resp_b = 2'd0; golden_b = 8'd0;
    #12;
    tests_run++;
    if ({busy_a, done_a, pass_a, ready_a, count_a, sig_a} !== {4'b0000, 16'd0, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset_a: b/d/p/r=%b%b%b%b cnt=%0d sig=%h expected 0000 0 00",
               busy_a, done_a, pass_a, ready_a, count_a, sig_a);
    end
    tests_run++;
    if (sig_b !== 8'h80) begin
      tests_failed++;
      $display("FAIL reset_seed_b: sig=%h expected 80", sig_b);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    // mid-run reset with valid held high
    start_a = 1'b1; tick(); start_a = 1'b0;
    valid_a = 1'b1; resp_a = 2'b11;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy_a, done_a, pass_a, ready_a, count_a, sig_a} !== {4'b0000, 16'd0, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset_midrun: b/d/p/r=%b%b%b%b cnt=%0d sig=%h expected 0000 0 00",
               busy_a, done_a, pass_a, ready_a, count_a, sig_a);
    end
    tick();
    rst_n = 1'b1; valid_a = 1'b0;
    tick();
    tests_run++;
    if ({busy_a, ready_a, sig_a} !== {2'b00, 8'h00}) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy=%b ready=%b sig=%h expected 0 0 00", busy_a, ready_a, sig_a);
    end
  endtask

  task automatic run_directed(input string name, input logic [1:0] seq [4],
                              input logic [7:0] exp_sig [4], input logic exp_pass);
    golden_a = 8'h09;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tests_run++;
    if ({busy_a, ready_a, count_a} !== {2'b11, 16'd0}) begin
      tests_failed++;
      $display("FAIL %s_start: busy=%b ready=%b cnt=%0d expected 1 1 0", name, busy_a, ready_a, count_a);
    end
    for (int i = 0; i < 4; i++) begin
      resp_a = seq[i]; valid_a = 1'b1;
      tick();
      tests_run++;
      if (sig_a !== exp_sig[i] || count_a !== 16'(i + 1)) begin
        tests_failed++;
        $display("FAIL %s_accept%0d: sig=%h cnt=%0d expected %h %0d", name, i, sig_a, count_a, exp_sig[i], i + 1);
      end
    end
    valid_a = 1'b0;
    tests_run++;
    if ({done_a, pass_a, ready_a, busy_a} !== {1'b1, exp_pass, 2'b00}) begin
      tests_failed++;
      $display("FAIL %s_done: done=%b pass=%b ready=%b busy=%b expected 1 %b 0 0",
               name, done_a, pass_a, ready_a, busy_a, exp_pass);
    end
  endtask

  task automatic test_fault_free();
    logic [1:0] seq [4];
    logic [7:0] exp [4];
    seq = '{2'b00, 2'b10, 2'b01, 2'b11};
    exp = '{8'h00, 8'h02, 8'h05, 8'h09};
    run_directed("fault_free", seq, exp, 1'b1);
  endtask

  task automatic test_stuck_at();
    logic [1:0] seq [4];
    logic [7:0] exp [4];
    seq = '{2'b00, 2'b10, 2'b00, 2'b10};
    exp = '{8'h00, 8'h02, 8'h04, 8'h0A};
    run_directed("stuck_at0", seq, exp, 1'b0);
  endtask

  task automatic test_feedback();
    golden_b = 8'h1D;
    start_b = 1'b1; tick(); start_b = 1'b0;
    valid_b = 1'b1; resp_b = 2'b00;
    tick();
    valid_b = 1'b0;
    tests_run++;
    if ({sig_b, done_b, pass_b, busy_b} !== {8'h1D, 3'b110}) begin
      tests_failed++;
      $display("FAIL feedback_tap: sig=%h done=%b pass=%b busy=%b expected 1d 1 1 0", sig_b, done_b, pass_b, busy_b);
    end
  endtask

  task automatic test_backpressure();
    logic       vpat [7];
    logic [7:0] s;
    int         c;
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    s = 8'h00; c = 0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      valid_a = vpat[i];
      resp_a  = 2'($urandom_range(0, 3));
      if (vpat[i]) begin
        s = model_step(s, resp_a);
        c++;
      end
      tick();
      tests_run++;
      if (sig_a !== s || count_a !== 16'(c)) begin
        tests_failed++;
        $display("FAIL backpressure_step%0d: sig=%h cnt=%0d expected %h %0d", i, sig_a, count_a, s, c);
      end
    end
    tests_run++;
    if (done_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_done: done=%b expected 1", done_a);
    end
    valid_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      resp_a = 2'($urandom_range(0, 3));
      tick();
    end
    valid_a = 1'b0;
    tests_run++;
    if ({sig_a, count_a, ready_a, done_a} !== {s, 16'd4, 2'b01}) begin
      tests_failed++;
      $display("FAIL valid_in_done: sig=%h cnt=%0d ready=%b done=%b expected %h 4 0 1",
               sig_a, count_a, ready_a, done_a, s);
    end
  endtask

  task automatic test_restart();
    logic [7:0] s;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tests_run++;
    if ({busy_a, done_a, pass_a, sig_a, count_a} !== {3'b100, 8'h00, 16'd0}) begin
      tests_failed++;
      $display("FAIL restart: busy=%b done=%b pass=%b sig=%h cnt=%0d expected 1 0 0 00 0",
               busy_a, done_a, pass_a, sig_a, count_a);
    end
    valid_a = 1'b1; resp_a = 2'b01; s = model_step(8'h00, 2'b01);
    tick();
    valid_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tests_run++;
    if ({count_a, busy_a, sig_a} !== {16'd1, 1'b1, s}) begin
      tests_failed++;
      $display("FAIL start_in_run: cnt=%0d busy=%b sig=%h expected 1 1 %h", count_a, busy_a, sig_a, s);
    end
    valid_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      resp_a = 2'(i + 1);
      s = model_step(s, resp_a);
      tick();
    end
    valid_a = 1'b0;
    tests_run++;
    if ({done_a, sig_a} !== {1'b1, s}) begin
      tests_failed++;
      $display("FAIL restart_finish: done=%b sig=%h expected 1 %h", done_a, sig_a, s);
    end
  endtask

  task automatic test_random();
    logic [1:0] r [4];
    logic [7:0] exp;
    logic       want_pass;
    int         idx, cycles;
    logic       v;
    for (int run = 0; run < 8; run++) begin
      exp = 8'h00;
      for (int k = 0; k < 4; k++) begin
        r[k] = 2'($urandom_range(0, 3));
        exp  = model_step(exp, r[k]);
      end
      want_pass = 1'($urandom_range(0, 1));
      golden_a  = want_pass ? exp : exp ^ (8'h01 << $urandom_range(0, 7));
      start_a = 1'b1; tick(); start_a = 1'b0;
      idx = 0; cycles = 0;
      while (idx < 4 && cycles < 100) begin
        v = 1'($urandom_range(0, 1));
        valid_a = v;
        resp_a  = v ? r[idx] : 2'($urandom_range(0, 3));
        tick();
        if (v) idx++;
        cycles++;
      end
      valid_a = 1'b0;
      tests_run++;
      if (cycles >= 100 || {done_a, sig_a, pass_a} !== {1'b1, exp, want_pass}) begin
        tests_failed++;
        $display("FAIL random_run%0d: done=%b sig=%h pass=%b expected 1 %h %b (cycles=%0d)",
                 run, done_a, sig_a, pass_a, exp, want_pass, cycles);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_at();
    test_feedback();
    test_backpressure();
    test_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
